urxd_crc_bl_p: RTL and testbench
================================

Name: urxd_crc_bl_p

Overview:
- Parametrised UART block receiver with CRC-16 check; successor to the fixed-format UART/CRC receiver.
- Receives framed blocks: command byte, length byte, ADR_W/8 address bytes (MSB first), data bytes, 2 CRC bytes (LSB first).
- Emits write strobes plus an auto-incrementing address for the memory-side writer. Reports block success, CRC failure and framing failure as single-cycle pulses.

Parameters:
- NT, 434: clock cycles per UART bit period (>=8).
- ADR_W, 16: address width in bits; multiple of 8, range 8..32.
- LEN_W, 8: width of the length field, lbl, and the byte counters; 8 only (one length byte).
- PAUSE, 10: idle bit periods that terminate a block.
- CRC_POLY, 16'hA001: reflected polynomial, applied on right shift.
- CRC_INIT, 16'hFFFF: CRC preset at block start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- urxd  in  1  asynchronous UART line, idle high
- com  out  8  latched command byte
- lbl  out  LEN_W  latched block length
- wr_adr  out  ADR_W  current write address
- rx_dat  out  8  last received byte
- ok_rx_byte  out  1  pulse: byte received with a valid stop bit
- ce_wr_dat  out  1  pulse: write rx_dat at wr_adr
- en_rx_bl  out  1  high while a block is in progress
- cb_byte  out  LEN_W  bytes received in the current block
- crc  out  16  running CRC register
- ok_rx_bl  out  1  pulse: block ended with crc==0
- err_crc  out  1  pulse: block ended with crc!=0, or block too short
- err_frame  out  1  pulse: stop bit sampled low

Behaviour:
- Reset: every output and internal register is 0, except crc=CRC_INIT. FSMs go to IDLE. The synchroniser is preset to 1 (line idle).
- Input: 2-flop synchroniser, then a falling-edge detector on the synchronised line.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, go to START and clear the bit-period counter.
  - START: sample at NT/2. Low goes to DATA. High is a glitch: go back to IDLE and count nothing.
  - DATA: 8 samples at NT intervals, LSB first, shifted into rx_dat. Each sample also updates the CRC: fb=crc[0]^bit; crc<=(crc>>1)^(fb?CRC_POLY:0).
  - STOP: sample. High gives ok_rx_byte=1 for one cycle and returns to IDLE. Low gives err_frame=1 for one cycle, aborts the block (en_rx_bl=0, cb_byte=0), and returns to IDLE only after the line has been high for 1 full bit period.
- Block control:
  - A START accepted while en_rx_bl=0 sets en_rx_bl=1 and loads crc=CRC_INIT in the same cycle.
  - Each ok_rx_byte increments cb_byte, saturating at 2^LEN_W-1.
  - Field decode uses cb_byte at the time of ok_rx_byte:
    - 0 = com
    - 1 = lbl
    - 2..1+ADR_W/8 = wr_adr, byte-wise, MSB first
    - beyond that = data
- Write strobe:
  - ce_wr_dat = ok_rx_byte & data phase & (com==8'h00 | com==8'h01) & wr_cnt<lbl.
  - wr_cnt is cleared when com is latched and increments on each ce_wr_dat.
  - The 2 trailing CRC bytes therefore produce no write when lbl is exact.
  - wr_adr increments by 1 in the cycle after each ce_wr_dat and wraps modulo 2^ADR_W.
- Read commands (8'h80, 8'h81): no ce_wr_dat is generated. Fields are still latched and the CRC is still checked.
- Pause and block end:
  - A pause counter counts bit periods while the byte FSM is IDLE and en_rx_bl=1. It clears on every START.
  - When it reaches PAUSE the block ends in a single cycle: en_rx_bl=0, cb_byte=0.
  - In that same cycle exactly one of ok_rx_bl or err_crc pulses.
  - ok_rx_bl requires crc==0 and cb_byte>=4+ADR_W/8. Anything else gives err_crc.
- Simultaneous events:
  - A falling edge in the same cycle as block end starts a new block: en_rx_bl=1 the next cycle, crc=CRC_INIT.
  - rst has priority over everything.
- Reset mid-byte or mid-block: the partial data is dropped, and none of ok_rx_byte, ce_wr_dat or the end-of-block pulses fire.
- Latency: ok_rx_byte fires 9.5·NT + 3 cycles after the start-bit falling edge on urxd (±1 cycle).

Optional Feature:
- Macro: URXD_PARITY_EN.
- Defined:
  - An even-parity bit is expected after D7 and sampled in an extra PAR state between DATA and STOP. It is not fed into the CRC.
  - On a mismatch, err_frame pulses at the stop sample instead of ok_rx_byte, and the block aborts exactly as for a bad stop bit.
- Undefined:
  - Frame is 8N1. The PAR state and its logic are absent.

Test Plan:
- NT=16, ADR_W=16. Send 00 02 12 34 AA 55 plus a correct CRC (LSB first), then idle for 10 bit periods.
  - Expect ce_wr_dat ×2 with (wr_adr, rx_dat) = (1234, AA) then (1235, 55).
  - Expect one ok_rx_bl pulse and no err_crc.
- Same block with one data bit flipped -> two ce_wr_dat pulses still occur, then err_crc=1 and ok_rx_bl=0 at the pause.
- Address wrap: send 01 03 FF FF 11 22 33 plus CRC.
  - Expect writes at wr_adr FFFF, 0000, 0001.
- Stop bit forced low on byte 3 -> err_frame pulse, en_rx_bl=0, cb_byte=0. No ce_wr_dat and no ok_rx_bl follow until a new valid block arrives.
- Read command: send 80 04 00 10 plus CRC -> no ce_wr_dat, com=80, lbl=04, ok_rx_bl=1.
- rst asserted for 1 cycle during the lbl byte -> all outputs 0 and crc=FFFF. A subsequent valid block is received correctly.

Source files
------------

// File: rtl/urxd_crc_bl_p_if.sv
// urxd_crc_bl_p_if: UART line plus block-receiver status/write bus
interface urxd_crc_bl_p_if #(parameter int ADR_W = 16, parameter int LEN_W = 8);
  logic             urxd;
  logic [7:0]       com;
  logic [LEN_W-1:0] lbl;
  logic [ADR_W-1:0] wr_adr;
  logic [7:0]       rx_dat;
  logic             ok_rx_byte;
  logic             ce_wr_dat;
  logic             en_rx_bl;
  logic [LEN_W-1:0] cb_byte;
  logic [15:0]      crc;
  logic             ok_rx_bl;
  logic             err_crc;
  logic             err_frame;
  modport master (input urxd, output com, lbl, wr_adr, rx_dat, ok_rx_byte, ce_wr_dat,
                  en_rx_bl, cb_byte, crc, ok_rx_bl, err_crc, err_frame);
  modport slave  (output urxd, input com, lbl, wr_adr, rx_dat, ok_rx_byte, ce_wr_dat,
                  en_rx_bl, cb_byte, crc, ok_rx_bl, err_crc, err_frame);
endinterface

// File: rtl/urxd_crc_bl_p.sv
// urxd_crc_bl_p: UART block receiver with CRC-16 check and write strobes; URXD_PARITY_EN adds even parity
module urxd_crc_bl_p #(
  parameter int          NT       = 434,
  parameter int          ADR_W    = 16,
  parameter int          LEN_W    = 8,
  parameter int          PAUSE    = 10,
  parameter logic [15:0] CRC_POLY = 16'hA001,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  urxd_crc_bl_p_if.master bus
);
  localparam int AB = ADR_W / 8;
  localparam int CW = $clog2(NT);
  localparam int PW = $clog2(PAUSE + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
`ifdef URXD_PARITY_EN
  localparam logic [2:0] PAR   = 3'd3;
`endif
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;
  logic s0, s1, s2;
  logic [2:0] st;
  logic [CW-1:0] cnt;
  logic [2:0] bcnt;
  logic [PW-1:0] pcnt;
  logic [LEN_W-1:0] wr_cnt, lbl, cb;
  logic [7:0] com, rx_dat;
  logic [ADR_W-1:0] wr_adr;
  logic [15:0] crc;
  logic ok_rx_byte, en, ok_rx_bl, err_crc, err_frame;
`ifdef URXD_PARITY_EN
  logic par_err;
`endif
  logic fall, bit_end, half, bl_end, data_ph, ce, stop_ok;
  logic [15:0] crc_nx;
  always_comb begin
    fall    = s2 & ~s1;
    bit_end = cnt == CW'(NT - 1);
    half    = cnt == CW'(NT / 2);
    bl_end  = en && st == IDLE && pcnt == PW'(PAUSE);
    data_ph = cb >= LEN_W'(2 + AB);
    ce      = ok_rx_byte && data_ph && (com == 8'h00 || com == 8'h01) && wr_cnt < lbl;
    crc_nx  = {1'b0, crc[15:1]} ^ ((crc[0] ^ s1) ? CRC_POLY : 16'h0000);
`ifdef URXD_PARITY_EN
    stop_ok = s1 & ~par_err;
`else
    stop_ok = s1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s0, s1, s2} <= 3'b111;
      st <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      pcnt <= '0;
      wr_cnt <= '0;
      lbl <= '0;
      cb <= '0;
      com <= '0;
      rx_dat <= '0;
      wr_adr <= '0;
      crc <= CRC_INIT;
      {ok_rx_byte, en, ok_rx_bl, err_crc, err_frame} <= '0;
`ifdef URXD_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      s0 <= bus.urxd;
      s1 <= s0;
      s2 <= s1;
      {ok_rx_byte, ok_rx_bl, err_crc, err_frame} <= '0;
      cnt <= cnt + 1'b1;
      case (st)
        IDLE:
          if (fall) begin
            st <= START;
            cnt <= '0;
            pcnt <= '0;
          end else if (bit_end) begin
            cnt <= '0;
            if (en) pcnt <= pcnt + 1'b1;
          end
        START:
          if (half) begin
            st <= s1 ? IDLE : DATA;
            cnt <= '0;
            bcnt <= '0;
            if (!s1 && !en) begin
              en <= 1'b1;
              crc <= CRC_INIT;
            end
          end
        DATA:
          if (bit_end) begin
            cnt <= '0;
            rx_dat <= {s1, rx_dat[7:1]};
            crc <= crc_nx;
            bcnt <= bcnt + 1'b1;
`ifdef URXD_PARITY_EN
            if (bcnt == 3'd7) st <= PAR;
`else
            if (bcnt == 3'd7) st <= STOP;
`endif
          end
`ifdef URXD_PARITY_EN
        PAR:
          if (bit_end) begin
            cnt <= '0;
            par_err <= s1 ^ (^rx_dat);
            st <= STOP;
          end
`endif
        STOP:
          if (bit_end) begin
            cnt <= '0;
            if (stop_ok) begin
              ok_rx_byte <= 1'b1;
              st <= IDLE;
            end else begin
              err_frame <= 1'b1;
              en <= 1'b0;
              cb <= '0;
              st <= BRK;
            end
          end
        BRK: begin
          cnt <= s1 ? cnt + 1'b1 : '0;
          if (s1 && bit_end) begin
            cnt <= '0;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
      // field decode sees cb as it stood when the byte arrived
      if (ok_rx_byte) begin
        if (cb != '1) cb <= cb + 1'b1;
        if (cb == '0) begin
          com <= rx_dat;
          wr_cnt <= '0;
        end else if (cb == LEN_W'(1)) lbl <= rx_dat;
        else if (!data_ph) wr_adr <= (wr_adr << 8) | ADR_W'(rx_dat);
      end
      if (ce) begin
        wr_cnt <= wr_cnt + 1'b1;
        wr_adr <= wr_adr + 1'b1;
      end
      if (bl_end) begin
        en <= fall;
        cb <= '0;
        pcnt <= '0;
        if (crc == 16'h0000 && cb >= LEN_W'(4 + AB)) ok_rx_bl <= 1'b1;
        else err_crc <= 1'b1;
        if (fall) crc <= CRC_INIT;
      end
    end
  end
  assign bus.com        = com;
  assign bus.lbl        = lbl;
  assign bus.wr_adr     = wr_adr;
  assign bus.rx_dat     = rx_dat;
  assign bus.ok_rx_byte = ok_rx_byte;
  assign bus.ce_wr_dat  = ce;
  assign bus.en_rx_bl   = en;
  assign bus.cb_byte    = cb;
  assign bus.crc        = crc;
  assign bus.ok_rx_bl   = ok_rx_bl;
  assign bus.err_crc    = err_crc;
  assign bus.err_frame  = err_frame;
endmodule

// File: tb/tb_urxd_crc_bl_p.sv
// tb_urxd_crc_bl_p: directed block-receiver checks at NT=16, ADR_W=16
module tb_urxd_crc_bl_p;
  localparam int NT = 16;
  logic clk = 0, rst = 1;
  int n_chk = 0, n_err = 0;
  int n_wr = 0, n_ok = 0, n_ec = 0, n_ef = 0, n_byte = 0;
  logic [15:0] wa[64];
  logic [7:0] wd[64];
  logic [7:0] msg[$];
  int b_wr, b_ok, b_ec, b_ef, b_byte;
  urxd_crc_bl_p_if #(.ADR_W(16), .LEN_W(8)) bus ();
  urxd_crc_bl_p #(.NT(NT), .ADR_W(16), .LEN_W(8), .PAUSE(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.ce_wr_dat && n_wr < 64) begin
      wa[n_wr] = bus.wr_adr;
      wd[n_wr] = bus.rx_dat;
      n_wr++;
    end
    if (bus.ok_rx_bl) n_ok++;
    if (bus.err_crc) n_ec++;
    if (bus.err_frame) n_ef++;
    if (bus.ok_rx_byte) n_byte++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic mark;
    b_wr = n_wr; b_ok = n_ok; b_ec = n_ec; b_ef = n_ef; b_byte = n_byte;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.urxd = 0;
    repeat (NT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.urxd = b[i];
      repeat (NT) @(negedge clk);
    end
    bus.urxd = stop;
    repeat (NT) @(negedge clk);
    bus.urxd = 1;
  endtask
  task automatic send_blk(input int flip);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (msg[i])
      for (int j = 0; j < 8; j++) c = (c >> 1) ^ ((c[0] ^ msg[i][j]) ? 16'hA001 : 16'h0000);
    foreach (msg[i]) send_byte(i == flip ? msg[i] ^ 8'h01 : msg[i], 1'b1);
    send_byte(c[7:0], 1'b1);
    send_byte(c[15:8], 1'b1);
  endtask
  task automatic idle_bits(input int n);
    repeat (n * NT) @(negedge clk);
  endtask
  initial begin
    bus.urxd = 1;
    repeat (4) @(negedge clk);
    chk("rst_com", bus.com, 0);
    chk("rst_wr_adr", bus.wr_adr, 0);
    chk("rst_en", bus.en_rx_bl, 0);
    chk("rst_crc", bus.crc, 16'hFFFF);
    rst = 0;
    idle_bits(2);
    // basic write block
    mark();
    msg = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAA, 8'h55};
    send_blk(-1);
    chk("a_en_busy", bus.en_rx_bl, 1);
    idle_bits(12);
    chk("a_nwr", n_wr - b_wr, 2);
    chk("a_w0", {wa[b_wr], wd[b_wr]}, 24'h1234AA);
    chk("a_w1", {wa[b_wr+1], wd[b_wr+1]}, 24'h123555);
    chk("a_ok", n_ok - b_ok, 1);
    chk("a_ecrc", n_ec - b_ec, 0);
    chk("a_bytes", n_byte - b_byte, 8);
    chk("a_adr_after", bus.wr_adr, 16'h1236);
    chk("a_lbl", bus.lbl, 2);
    chk("a_en_end", bus.en_rx_bl, 0);
    chk("a_cb_end", bus.cb_byte, 0);
    // corrupted data bit
    mark();
    send_blk(4);
    idle_bits(12);
    chk("b_nwr", n_wr - b_wr, 2);
    chk("b_w0", {wa[b_wr], wd[b_wr]}, 24'h1234AB);
    chk("b_ok", n_ok - b_ok, 0);
    chk("b_ecrc", n_ec - b_ec, 1);
    // address wrap
    mark();
    msg = '{8'h01, 8'h03, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
    send_blk(-1);
    idle_bits(12);
    chk("c_nwr", n_wr - b_wr, 3);
    chk("c_w0", {wa[b_wr], wd[b_wr]}, 24'hFFFF11);
    chk("c_w1", {wa[b_wr+1], wd[b_wr+1]}, 24'h000022);
    chk("c_w2", {wa[b_wr+2], wd[b_wr+2]}, 24'h000133);
    chk("c_ok", n_ok - b_ok, 1);
    // stop bit low on byte 3
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    chk("d_ef", n_ef - b_ef, 1);
    chk("d_en", bus.en_rx_bl, 0);
    chk("d_cb", bus.cb_byte, 0);
    idle_bits(14);
    chk("d_nwr", n_wr - b_wr, 0);
    chk("d_ok", n_ok - b_ok, 0);
    chk("d_ecrc", n_ec - b_ec, 0);
    // read command
    mark();
    msg = '{8'h80, 8'h04, 8'h00, 8'h10};
    send_blk(-1);
    idle_bits(12);
    chk("e_nwr", n_wr - b_wr, 0);
    chk("e_com", bus.com, 8'h80);
    chk("e_lbl", bus.lbl, 8'h04);
    chk("e_adr", bus.wr_adr, 16'h0010);
    chk("e_ok", n_ok - b_ok, 1);
    // too short: CRC zero but only 3 bytes
    mark();
    msg = '{8'h00};
    send_blk(-1);
    chk("f_crc0", bus.crc, 16'h0000);
    idle_bits(12);
    chk("f_ok", n_ok - b_ok, 0);
    chk("f_ecrc", n_ec - b_ec, 1);
    // known CRC-16/MODBUS check value of "123456789"
    mark();
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1);
    chk("g_crc", bus.crc, 16'h4B37);
    idle_bits(12);
    chk("g_ecrc", n_ec - b_ec, 1);
    chk("g_ok", n_ok - b_ok, 0);
    // reset during the length byte
    send_byte(8'h01, 1'b1);
    bus.urxd = 0;
    repeat (3 * NT) @(negedge clk);
    mark();
    rst = 1;
    bus.urxd = 1;
    @(negedge clk);
    chk("h_com", bus.com, 0);
    chk("h_rx_dat", bus.rx_dat, 0);
    chk("h_crc", bus.crc, 16'hFFFF);
    chk("h_en", bus.en_rx_bl, 0);
    chk("h_cb", bus.cb_byte, 0);
    rst = 0;
    idle_bits(12);
    chk("h_quiet", (n_byte - b_byte) + (n_ok - b_ok) + (n_ec - b_ec) + (n_wr - b_wr), 0);
    mark();
    msg = '{8'h00, 8'h01, 8'h00, 8'h20, 8'h5A};
    send_blk(-1);
    idle_bits(12);
    chk("h_nwr", n_wr - b_wr, 1);
    chk("h_w0", {wa[b_wr], wd[b_wr]}, 24'h00205A);
    chk("h_ok", n_ok - b_ok, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
